// File: rtl/ariane_axi_pkg.sv
// AXI4 read-channel types shared by the Ariane read-port arbiter and its requesters.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ariane_axi_pkg;

    localparam int unsigned AxiAddrWidth = 64;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiIdWidth   = 4;

    // Default number of requesters sharing the read port (I-cache + D-cache refill).
    localparam int unsigned RdArbNumReq = 2;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
    } m_ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
    } m_r_chan_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_arb_state_e;

endpackage

// File: rtl/ariane_axi_rd_arbiter_rr_pick.sv
// Round-robin priority picker: first set valid bit at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module ariane_axi_rd_arbiter_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    // Scan NumReq candidates starting at rr_ptr; the first valid one wins.
    always_comb begin
        int unsigned cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = (32'(rr_ptr_i) + k) % NumReq;
            if (!any_o && valid_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/ariane_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port; one transaction in flight at a time.
// Latency: AR accepted in cycle N appears downstream in N+1; R beats pass through combinationally.
// Backpressure: R ready follows the granted requester's ready; AR ready only in IDLE.
module ariane_axi_rd_arbiter
    import ariane_axi_pkg::*;
#(
    parameter int unsigned NumReq   = RdArbNumReq,
    parameter int unsigned CntWidth = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  m_ar_chan_t [NumReq-1:0] req_ar_i,
    input  logic [NumReq-1:0]       req_ar_valid_i,
    output logic [NumReq-1:0]       req_ar_ready_o,
    output m_r_chan_t               req_r_o,
    output logic [NumReq-1:0]       req_r_valid_o,
    input  logic [NumReq-1:0]       req_r_ready_i,
    output m_ar_chan_t              mst_ar_o,
    output logic                    mst_ar_valid_o,
    input  logic                    mst_ar_ready_i,
    input  m_r_chan_t               mst_r_i,
    input  logic                    mst_r_valid_i,
    output logic                    mst_r_ready_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    rd_arb_state_e       state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     sel_q, sel_d;
    logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
    m_ar_chan_t          ar_q, ar_d;
    logic                err_q, err_d;

    logic [NumReq-1:0]   pick_gnt;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_any;

    logic                in_data;
    logic                r_hs;
    logic [CntWidth-1:0] exp_beats;
    logic [CntWidth-1:0] beats_now;
    logic                id_err;
    logic                cnt_err;

    ariane_axi_rd_arbiter_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_pick (
        .valid_i  (req_ar_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick_gnt),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Channel routing: AR grant in IDLE, R steered only to the granted requester in DATA.
    always_comb begin
        in_data        = (state_q == DATA);
        req_ar_ready_o = (state_q == IDLE && !rst_i) ? pick_gnt : '0;
        mst_ar_o       = ar_q;
        mst_ar_valid_o = (state_q == ADDR);
        req_r_o        = mst_r_i;
        req_r_valid_o  = '0;
        if (in_data) begin
            req_r_valid_o[sel_q] = mst_r_valid_i;
        end
        mst_r_ready_o  = in_data & req_r_ready_i[sel_q];
        r_hs           = mst_r_ready_o & mst_r_valid_i;
        busy_o         = (state_q != IDLE);
        err_o          = err_q;
    end

    // Protocol checks against the latched AR: wrong ID, short/long burst at LAST,
    // or surplus beats past the announced length.
    always_comb begin
        exp_beats = CntWidth'(ar_q.len) + CntWidth'(1);
        beats_now = beat_cnt_q + CntWidth'(1);
        id_err    = (mst_r_i.id != ar_q.id);
        cnt_err   = mst_r_i.last ? (beats_now != exp_beats) : (beat_cnt_q >= exp_beats);
    end

    // Next-state logic for the IDLE -> ADDR -> DATA -> IDLE transaction cycle.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        ar_d       = ar_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ar_d       = req_ar_i[pick_idx];
                    sel_d      = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (mst_ar_ready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    // Saturate so a runaway slave cannot wrap the counter back into range.
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beats_now;
                    end
                    err_d = id_err | cnt_err;
                    if (mst_r_i.last) begin
                        state_d  = IDLE;
                        rr_ptr_d = (sel_q == IdxW'(NumReq - 1)) ? '0 : sel_q + IdxW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            ar_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
            ar_q       <= ar_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ariane_axi_rd_arbiter.sv
// Directed bench for the Ariane AXI read arbiter.
// Latency: inputs driven on the falling edge, outputs sampled before the next rising edge.
// Backpressure: exercised on both AR (downstream ready) and R (requester ready).
module tb_ariane_axi_rd_arbiter;
    import ariane_axi_pkg::*;

    logic             clk;
    logic             rst;
    m_ar_chan_t [1:0] req_ar;
    logic [1:0]       req_ar_valid;
    logic [1:0]       req_ar_ready;
    m_r_chan_t        req_r;
    logic [1:0]       req_r_valid;
    logic [1:0]       req_r_ready;
    m_ar_chan_t       mst_ar;
    logic             mst_ar_valid;
    logic             mst_ar_ready;
    m_r_chan_t        mst_r;
    logic             mst_r_valid;
    logic             mst_r_ready;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    ariane_axi_rd_arbiter #(.NumReq(2), .CntWidth(9)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_ar_i       (req_ar),
        .req_ar_valid_i (req_ar_valid),
        .req_ar_ready_o (req_ar_ready),
        .req_r_o        (req_r),
        .req_r_valid_o  (req_r_valid),
        .req_r_ready_i  (req_r_ready),
        .mst_ar_o       (mst_ar),
        .mst_ar_valid_o (mst_ar_valid),
        .mst_ar_ready_i (mst_ar_ready),
        .mst_r_i        (mst_r),
        .mst_r_valid_i  (mst_r_valid),
        .mst_r_ready_o  (mst_r_ready),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic m_ar_chan_t mk_ar(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len);
        m_ar_chan_t a;
        a       = '0;
        a.addr  = addr;
        a.id    = id;
        a.len   = len;
        a.size  = 3'd3;
        a.burst = 2'b01;
        return a;
    endfunction

    function automatic m_r_chan_t mk_r(input logic [3:0] id, input logic [63:0] data, input logic last);
        m_r_chan_t r;
        r      = '0;
        r.id   = id;
        r.data = data;
        r.last = last;
        return r;
    endfunction

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Downstream accepts the AR immediately (one ADDR cycle).
    task automatic accept_ar();
        mst_ar_ready = 1'b1;
        step();
        mst_ar_ready = 1'b0;
    endtask

    // Present one R beat for a single cycle with the requester ready.
    task automatic send_beat(input m_r_chan_t r);
        mst_r       = r;
        mst_r_valid = 1'b1;
        step();
        mst_r_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (mst_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid: got %b exp 0", mst_ar_valid); end
        checks++; if (mst_ar !== m_ar_chan_t'('0)) begin errors++; $display("FAIL reset_ar_payload: got %h exp 0", mst_ar); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        checks++; if (req_r_valid !== 2'b00 || mst_r_ready !== 1'b0 || req_ar_ready !== 2'b00) begin
            errors++; $display("FAIL reset_handshakes: r_valid %b r_ready %b ar_ready %b exp all 0", req_r_valid, mst_r_ready, req_ar_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        m_ar_chan_t a0, a1, a0b;
        a0  = mk_ar(64'h1000, 4'd1, 8'd0);
        a1  = mk_ar(64'h2000, 4'd2, 8'd0);
        a0b = mk_ar(64'h3000, 4'd1, 8'd0);
        req_ar[0] = a0; req_ar[1] = a1; req_ar_valid = 2'b11;
        #1;
        checks++; if (req_ar_ready !== 2'b01) begin errors++; $display("FAIL rr_first: got %b exp 01", req_ar_ready); end
        step();
        req_ar_valid[0] = 1'b0;
        #1;
        checks++; if (req_ar_ready !== 2'b00) begin errors++; $display("FAIL rr_busy_ready_addr: got %b exp 00", req_ar_ready); end
        checks++; if (mst_ar !== a0) begin errors++; $display("FAIL rr_payload0: got %h exp %h", mst_ar, a0); end
        accept_ar();
        mst_r = mk_r(4'd1, 64'h11, 1'b1); mst_r_valid = 1'b1;
        #1;
        checks++; if (req_r_valid !== 2'b01) begin errors++; $display("FAIL rr_rvalid0: got %b exp 01", req_r_valid); end
        checks++; if (req_ar_ready !== 2'b00) begin errors++; $display("FAIL rr_no_grant_rlast: got %b exp 00", req_ar_ready); end
        step();
        mst_r_valid = 1'b0;
        req_ar[0] = a0b; req_ar_valid[0] = 1'b1;
        #1;
        checks++; if (req_ar_ready !== 2'b10) begin errors++; $display("FAIL rr_second: got %b exp 10", req_ar_ready); end
        step();
        req_ar_valid[1] = 1'b0;
        #1;
        checks++; if (mst_ar !== a1) begin errors++; $display("FAIL rr_payload1: got %h exp %h", mst_ar, a1); end
        accept_ar();
        mst_r = mk_r(4'd2, 64'h22, 1'b1); mst_r_valid = 1'b1;
        #1;
        checks++; if (req_r_valid !== 2'b10) begin errors++; $display("FAIL rr_rvalid1: got %b exp 10", req_r_valid); end
        step();
        mst_r_valid = 1'b0;
        #1;
        checks++; if (req_ar_ready !== 2'b01) begin errors++; $display("FAIL rr_third: got %b exp 01", req_ar_ready); end
        step();
        req_ar_valid[0] = 1'b0;
        #1;
        checks++; if (mst_ar !== a0b) begin errors++; $display("FAIL rr_payload2: got %h exp %h", mst_ar, a0b); end
        accept_ar();
        send_beat(mk_r(4'd1, 64'h33, 1'b1));
    endtask

    task automatic test_single();
        m_ar_chan_t a;
        m_r_chan_t  r;
        a = mk_ar(64'h8000_0000, 4'd3, 8'd0);
        r = mk_r(4'd3, 64'hDEAD_BEEF, 1'b1);
        req_ar[0] = a; req_ar_valid = 2'b01;
        #1;
        checks++; if (req_ar_ready !== 2'b01) begin errors++; $display("FAIL single_ar_ready: got %b exp 01", req_ar_ready); end
        step();
        req_ar_valid = 2'b00;
        #1;
        checks++; if (mst_ar_valid !== 1'b1) begin errors++; $display("FAIL single_ar_valid: got %b exp 1", mst_ar_valid); end
        checks++; if (mst_ar !== a) begin errors++; $display("FAIL single_ar_payload: got %h exp %h", mst_ar, a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
        accept_ar();
        mst_r = r; mst_r_valid = 1'b1;
        #1;
        checks++; if (mst_ar_valid !== 1'b0) begin errors++; $display("FAIL single_ar_valid_drop: got %b exp 0", mst_ar_valid); end
        checks++; if (req_r_valid !== 2'b01) begin errors++; $display("FAIL single_r_valid: got %b exp 01", req_r_valid); end
        checks++; if (req_r !== r) begin errors++; $display("FAIL single_r_payload: got %h exp %h", req_r, r); end
        checks++; if (mst_r_ready !== 1'b1) begin errors++; $display("FAIL single_r_ready: got %b exp 1", mst_r_ready); end
        step();
        mst_r_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", err); end
    endtask

    task automatic test_r_backpressure();
        m_r_chan_t b1;
        req_ar[1] = mk_ar(64'h4000, 4'd4, 8'd1); req_ar_valid = 2'b10;
        #1;
        checks++; if (req_ar_ready !== 2'b10) begin errors++; $display("FAIL bp_ar_ready: got %b exp 10", req_ar_ready); end
        step();
        req_ar_valid = 2'b00;
        accept_ar();
        b1 = mk_r(4'd4, 64'hCAFE_0001, 1'b0);
        req_r_ready = 2'b01; mst_r = b1; mst_r_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mst_r_ready !== 1'b0 || req_r_valid !== 2'b10 || req_r !== b1) begin
                errors++; $display("FAIL bp_stall%0d: ready %b valid %b data %h exp 0 10 %h", i, mst_r_ready, req_r_valid, req_r, b1);
            end
            step();
        end
        req_r_ready = 2'b11;
        #1;
        checks++; if (mst_r_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b exp 1", mst_r_ready); end
        step();
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_mid: got %b exp 1", busy); end
        send_beat(mk_r(4'd4, 64'hCAFE_0002, 1'b1));
        #1;
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL bp_done: busy %b err %b exp 0 0", busy, err); end
    endtask

    task automatic test_errors();
        // Early LAST: len=3 but LAST on beat 2.
        req_ar[0] = mk_ar(64'h5000, 4'd3, 8'd3); req_ar_valid = 2'b01;
        step();
        req_ar_valid = 2'b00;
        accept_ar();
        send_beat(mk_r(4'd3, 64'h1, 1'b0));
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL early_beat1: got %b exp 0", err); end
        send_beat(mk_r(4'd3, 64'h2, 1'b1));
        #1;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL early_last: err %b busy %b exp 1 0", err, busy); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL early_pulse_width: got %b exp 0", err); end
        // Wrong R ID.
        req_ar[1] = mk_ar(64'h6000, 4'd3, 8'd0); req_ar_valid = 2'b10;
        step();
        req_ar_valid = 2'b00;
        accept_ar();
        send_beat(mk_r(4'd5, 64'h3, 1'b1));
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL id_mismatch: got %b exp 1", err); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL id_pulse_width: got %b exp 0", err); end
        // Surplus beats: len=0, LAST only on the third beat.
        req_ar[0] = mk_ar(64'h7000, 4'd2, 8'd0); req_ar_valid = 2'b01;
        step();
        req_ar_valid = 2'b00;
        accept_ar();
        send_beat(mk_r(4'd2, 64'h4, 1'b0));
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL surplus_beat1: got %b exp 0", err); end
        send_beat(mk_r(4'd2, 64'h5, 1'b0));
        #1;
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL surplus_beat2: err %b busy %b exp 1 1", err, busy); end
        send_beat(mk_r(4'd2, 64'h6, 1'b1));
        #1;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL surplus_last: err %b busy %b exp 1 0", err, busy); end
        step();
    endtask

    task automatic test_ar_stall();
        m_ar_chan_t a;
        a = mk_ar(64'h9000, 4'd7, 8'd0);
        req_ar[1] = a; req_ar_valid = 2'b10;
        step();
        req_ar[0] = mk_ar(64'hA000, 4'd8, 8'd0); req_ar_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mst_ar_valid !== 1'b1 || mst_ar !== a || req_ar_ready !== 2'b00) begin
                errors++; $display("FAIL ar_stall%0d: valid %b ar %h ready %b exp 1 %h 00", i, mst_ar_valid, mst_ar, req_ar_ready, a);
            end
            step();
        end
        accept_ar();
        send_beat(mk_r(4'd7, 64'h7, 1'b1));
        #1;
        checks++; if (req_ar_ready !== 2'b01) begin errors++; $display("FAIL ar_stall_next_grant: got %b exp 01", req_ar_ready); end
        step();
        req_ar_valid = 2'b00;
        accept_ar();
        send_beat(mk_r(4'd8, 64'h8, 1'b1));
    endtask

    task automatic test_reset_mid_data();
        m_ar_chan_t a;
        req_ar[1] = mk_ar(64'hB000, 4'd6, 8'd3); req_ar_valid = 2'b10;
        step();
        req_ar_valid = 2'b00;
        accept_ar();
        send_beat(mk_r(4'd6, 64'h9, 1'b0));
        mst_r = mk_r(4'd6, 64'hA, 1'b0); mst_r_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
        checks++; if (req_r_valid !== 2'b00 || mst_r_ready !== 1'b0 || mst_ar_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_valids: r_valid %b r_ready %b ar_valid %b exp 00 0 0", req_r_valid, mst_r_ready, mst_ar_valid);
        end
        checks++; if (mst_ar !== m_ar_chan_t'('0)) begin errors++; $display("FAIL rst_mid_payload: got %h exp 0", mst_ar); end
        mst_r_valid = 1'b0;
        // Pointer was 1 before reset; after reset requester 0 must win a tie.
        req_ar[0] = mk_ar(64'hC000, 4'd1, 8'd0);
        a = mk_ar(64'hD000, 4'd9, 8'd0);
        req_ar[1] = a; req_ar_valid = 2'b11;
        #1;
        checks++; if (req_ar_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_rr_ptr: got %b exp 01", req_ar_ready); end
        step();
        req_ar_valid[0] = 1'b0;
        accept_ar();
        send_beat(mk_r(4'd1, 64'hB, 1'b1));
        #1;
        checks++; if (req_ar_ready !== 2'b10) begin errors++; $display("FAIL rst_new_req1: got %b exp 10", req_ar_ready); end
        step();
        req_ar_valid = 2'b00;
        #1;
        checks++; if (mst_ar !== a || mst_ar_valid !== 1'b1) begin errors++; $display("FAIL rst_new_payload: got %h/%b exp %h/1", mst_ar, mst_ar_valid, a); end
        accept_ar();
        mst_r = mk_r(4'd9, 64'hC, 1'b1); mst_r_valid = 1'b1;
        #1;
        checks++; if (req_r_valid !== 2'b10) begin errors++; $display("FAIL rst_new_rvalid: got %b exp 10", req_r_valid); end
        step();
        mst_r_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_new_done: busy %b err %b exp 0 0", busy, err); end
    endtask

    initial begin
        rst          = 1'b1;
        req_ar       = '0;
        req_ar_valid = 2'b00;
        req_r_ready  = 2'b11;
        mst_ar_ready = 1'b0;
        mst_r        = '0;
        mst_r_valid  = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_r_backpressure();
        test_errors();
        test_ar_stall();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ariane_axi_rd_arbiter.md
Name: ariane_axi_rd_arbiter

Overview:
- Round-robin arbiter that shares one AXI4 read port (ariane_axi_pkg types, 64-bit address and data, 4-bit ID) between NumReq requesters, such as the I-cache and D-cache refill engines.
- Only one transaction is in flight at a time. A grant is held from AR acceptance until the matching RLAST handshake.
- R beats are routed back to the granted requester only.
- Beat count and R ID are checked against the latched AR, and a mismatch is reported.

Parameters:
- NumReq, 2, number of requesters (>=2).
- CntWidth, 9, beat counter width; must hold ar.len+1 (up to 256).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- req_ar_i  in  [NumReq] x m_ar_chan_t  per-requester AR payload
- req_ar_valid_i  in  NumReq  AR valid per requester
- req_ar_ready_o  out  NumReq  AR ready per requester
- req_r_o  out  m_r_chan_t  R payload, broadcast to all requesters
- req_r_valid_o  out  NumReq  R valid, one-hot to the granted requester
- req_r_ready_i  in  NumReq  R ready per requester
- mst_ar_o  out  m_ar_chan_t  downstream AR payload (registered)
- mst_ar_valid_o  out  1  downstream AR valid
- mst_ar_ready_i  in  1  downstream AR ready
- mst_r_i  in  m_r_chan_t  downstream R payload
- mst_r_valid_i  in  1  downstream R valid
- mst_r_ready_o  out  1  downstream R ready
- busy_o  out  1  state != IDLE
- err_o  out  1  one-cycle pulse on a protocol mismatch

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, rr_ptr=0, sel=0, beat_cnt=0.
  - mst_ar_o=0, err_o=0.
  - All valid/ready outputs are 0 from the next cycle.
  - A reset mid-transaction abandons it; no drain is performed.
- IDLE:
  - Pick winner g = the first requester with req_ar_valid_i set, searching upward from rr_ptr with wrap modulo NumReq.
  - req_ar_ready_o[g]=1 combinationally in the same cycle; every other ready is 0.
  - On that handshake: latch req_ar_i[g] into mst_ar_o, set sel=g, beat_cnt=0, move to ADDR.
  - With no valid requester, remain in IDLE.
- ADDR:
  - mst_ar_valid_o=1 with the payload held stable.
  - On mst_ar_ready_i, move to DATA.
  - All req_ar_ready_o are 0.
  - Latency: requester AR handshake in cycle N gives mst_ar_valid_o=1 in cycle N+1.
- DATA:
  - req_r_o=mst_r_i, combinational pass-through.
  - req_r_valid_o[sel]=mst_r_valid_i; all other valids are 0.
  - mst_r_ready_o=req_r_ready_i[sel].
  - beat_cnt increments on each R handshake.
  - On a handshake with r.last=1: go to IDLE, rr_ptr=(sel+1) mod NumReq.
- Error pulse (err_o=1 for one cycle): on any DATA handshake where r.id != latched ar.id, or on the last beat where beat_cnt+1 != ar.len+1. Transfer continues regardless.
- A beat arriving after beat_cnt reaches ar.len+1 without last: err_o pulses on every such beat, and the FSM keeps waiting for last.
- R valid arriving in IDLE or ADDR: mst_r_ready_o=0 and it is not forwarded.
- Throughput: there is one IDLE bubble after each RLAST, with no grant in the RLAST cycle.
- mst_r_ready_o never depends on mst_r_valid_i. All AXI valids hold until their handshake completes.

Decomposition:
- ariane_axi_pkg additions:
  - rd_arb_state_e enum {IDLE, ADDR, DATA}
  - default NumReq localparam
- Sub-module rr_pick: combinational round-robin priority picker. Inputs: valid vector, rr_ptr. Outputs: one-hot grant and index.
- Arbiter top holds the FSM, the payload register, the counter and the routing logic.

Test Plan:
1. Requester 0: AR addr=0x8000_0000, id=3, len=0. Expect mst_ar_valid_o the next cycle with the identical payload. Then one R beat (data=0xDEAD_BEEF, last=1, id=3) → req_r_valid_o=2'b01, err_o=0, busy_o falls the cycle after.
2. Both requesters valid right after reset → order is req0, req1, then req0 again. Each grant is preceded by an RLAST and an IDLE bubble. req1 ready stays 0 while req0 is busy.
3. Requester 1: len=1, two beats. Hold req_r_ready_i[1]=0 for 3 cycles → mst_r_ready_o=0 for those cycles, payload passed unchanged. Completion occurs on the second beat with last=1.
4. len=3 with last on beat 2 → err_o is 1 for exactly one cycle, FSM returns to IDLE. Separately, an R id of 5 against an AR id of 3 → err_o pulses on that beat.
5. mst_ar_ready_i held 0 for 5 cycles → mst_ar_valid_o stays 1 with a stable payload, and no other requester is granted.
6. rst_i asserted during DATA after 1 of 4 beats → next cycle busy_o=0, all valids 0, rr_ptr=0. A new req1 AR is then granted normally.
